pc_sequencer: RTL and testbench

Owns the program counter of the MIPS core and sequences the single shared 32-bit PC adder between sequential increment (PC+4) and branch-target computation. Drives the instruction-fetch request with a valid/ready handshake, absorbs stalls, and accepts redirects (branch, jump, jump-register) from decode/execute. A redirect that arrives while a fetch is blocked is held until that fetch completes.

---
 rtl/pc_sequencer_pkg.sv | 18 +
 rtl/pc_adder.sv | 13 +
 rtl/pc_sequencer.sv | 169 ++++++++++++++++
 tb/tb_pc_sequencer.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the program-counter sequencer.
// Contents: FSM state enum, PC increment constant, default reset PC and
// exception vector used by pc_sequencer.
package pc_sequencer_pkg;

    localparam int unsigned PC_W = 32;

    localparam logic [PC_W-1:0] PC_INC       = 32'd4;
    localparam logic [PC_W-1:0] DEF_RESET_PC = 32'h0000_3000;
    localparam logic [PC_W-1:0] DEF_EXC_VEC  = 32'h0000_4180;

    typedef enum logic [1:0] {
        ST_RST  = 2'd0,
        ST_RUN  = 2'd1,
        ST_PEND = 2'd2
    } state_t;

endpackage : pc_sequencer_pkg

// File: rtl/pc_adder.sv
// Shared 32-bit PC adder, purely combinational, wraps modulo 2^32.
// Ports: a, b operands; y sum (carry out discarded).
module pc_adder
    import pc_sequencer_pkg::*;
(
    input  logic [PC_W-1:0] a,
    input  logic [PC_W-1:0] b,
    output logic [PC_W-1:0] y
);

    assign y = a + b;

endmodule : pc_adder

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: owns the PC, drives the instruction-fetch
// valid/ready request, and applies branch / jump / jump-register redirects.
// A redirect arriving while a fetch is blocked is held in pend_pc until the
// blocked fetch transfers.
//
// Build option: PC_SEQ_ALIGN_CHK_EN -- misaligned redirect targets are
// replaced by EXC_VEC and misalign pulses one cycle. Without it targets are
// used as-is and misalign is tied low.
//
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   stall                       blocks the start of a new fetch
//   fetch_valid/fetch_ready     fetch handshake, fetch_pc is the address
//   br_req/br_taken/br_pc4/br_imm  resolved branch
//   j_req/j_index               J/JAL redirect
//   jr_req/jr_target            JR/JALR redirect
//   redir_pending               redirect latched, waiting on blocked fetch
//   misalign                    misaligned target seen (option only)
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEF_RESET_PC,
    parameter logic [31:0] EXC_VEC  = DEF_EXC_VEC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    output logic        fetch_valid,
    input  logic        fetch_ready,
    output logic [31:0] fetch_pc,
    input  logic        br_req,
    input  logic        br_taken,
    input  logic [31:0] br_pc4,
    input  logic [15:0] br_imm,
    input  logic        j_req,
    input  logic [25:0] j_index,
    input  logic        jr_req,
    input  logic [31:0] jr_target,
    output logic        redir_pending,
    output logic        misalign
);

    state_t            state_q, state_d;
    logic [PC_W-1:0]   pc_d;
    logic              valid_d;
    logic [PC_W-1:0]   pend_pc, pend_pc_d;
    logic              mis_d;

    logic              br_sel;
    logic              redir;
    logic [PC_W-1:0]   br_off;
    logic [PC_W-1:0]   add_a, add_b, add_y;
    logic [PC_W-1:0]   raw_tgt, tgt;
    logic              tgt_mis;

    // Adder belongs to a taken branch in its request cycle, else PC+4.
    assign br_sel = br_req & br_taken;
    assign br_off = {{14{br_imm[15]}}, br_imm, 2'b00};
    assign add_a  = br_sel ? br_pc4 : fetch_pc;
    assign add_b  = br_sel ? br_off : PC_INC;

    pc_adder u_adder (
        .a (add_a),
        .b (add_b),
        .y (add_y)
    );

    // Redirect priority: jr > j > taken branch.
    assign redir = jr_req | j_req | br_sel;

    always_comb begin
        raw_tgt = add_y;
        if (jr_req) begin
            raw_tgt = jr_target;
        end else if (j_req) begin
            raw_tgt = {fetch_pc[31:28], j_index, 2'b00};
        end
    end

`ifdef PC_SEQ_ALIGN_CHK_EN
    assign tgt_mis = redir && (raw_tgt[1:0] != 2'b00);
    assign tgt     = tgt_mis ? EXC_VEC : raw_tgt;
`else
    logic unused_exc_vec;
    assign unused_exc_vec = ^EXC_VEC;
    assign tgt_mis        = 1'b0;
    assign tgt            = raw_tgt;
`endif

    // Next-state and next-output logic.
    always_comb begin
        state_d   = state_q;
        pc_d      = fetch_pc;
        valid_d   = fetch_valid;
        pend_pc_d = pend_pc;
        mis_d     = 1'b0;

        case (state_q)
            ST_RST: begin
                state_d = ST_RUN;
                valid_d = ~stall;
            end
            ST_RUN: begin
                if (redir) begin
                    mis_d = tgt_mis;
                    if (fetch_valid && !fetch_ready) begin
                        pend_pc_d = tgt;
                        state_d   = ST_PEND;
                    end else begin
                        pc_d    = tgt;
                        valid_d = ~stall;
                    end
                end else if (!fetch_valid || fetch_ready) begin
                    if (fetch_valid) begin
                        pc_d = add_y;
                    end
                    valid_d = ~stall;
                end
            end
            ST_PEND: begin
                mis_d = tgt_mis;
                if (fetch_ready) begin
                    // Same-cycle new redirect beats the held one.
                    pc_d    = redir ? tgt : pend_pc;
                    valid_d = ~stall;
                    state_d = ST_RUN;
                end else if (redir) begin
                    pend_pc_d = tgt;
                end
            end
            default: begin
                state_d = ST_RST;
                valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_RST;
            fetch_pc      <= RESET_PC;
            fetch_valid   <= 1'b0;
            pend_pc       <= '0;
            redir_pending <= 1'b0;
        end else begin
            state_q       <= state_d;
            fetch_pc      <= pc_d;
            fetch_valid   <= valid_d;
            pend_pc       <= pend_pc_d;
            redir_pending <= (state_d == ST_PEND);
        end
    end

`ifdef PC_SEQ_ALIGN_CHK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign <= 1'b0;
        end else begin
            misalign <= mis_d;
        end
    end
`else
    logic unused_mis_d;
    assign unused_mis_d = mis_d;
    assign misalign     = 1'b0;
`endif

endmodule : pc_sequencer

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed steps from the test plan
// followed by randomized traffic against a transaction-level model.
module tb_pc_sequencer;

`ifdef PC_SEQ_ALIGN_CHK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif
    localparam logic [31:0] R_PC = 32'h0000_3000;
    localparam logic [31:0] X_VEC = 32'h0000_4180;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        fetch_valid;
    logic        fetch_ready;
    logic [31:0] fetch_pc;
    logic        br_req;
    logic        br_taken;
    logic [31:0] br_pc4;
    logic [15:0] br_imm;
    logic        j_req;
    logic [25:0] j_index;
    logic        jr_req;
    logic [31:0] jr_target;
    logic        redir_pending;
    logic        misalign;

    int errors = 0;
    int checks = 0;

    // Reference model state
    bit          m_in_rst;
    logic [31:0] m_pc;
    bit          m_valid;
    bit          m_pend;
    logic [31:0] m_pend_pc;
    bit          m_mis;

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .fetch_valid   (fetch_valid),
        .fetch_ready   (fetch_ready),
        .fetch_pc      (fetch_pc),
        .br_req        (br_req),
        .br_taken      (br_taken),
        .br_pc4        (br_pc4),
        .br_imm        (br_imm),
        .j_req         (j_req),
        .j_index       (j_index),
        .jr_req        (jr_req),
        .jr_target     (jr_target),
        .redir_pending (redir_pending),
        .misalign      (misalign)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_model();
        chk("pc", fetch_pc, m_pc);
        chk("valid", 32'(fetch_valid), 32'(m_valid));
        chk("pending", 32'(redir_pending), 32'(m_pend));
        chk("misalign", 32'(misalign), 32'(m_mis));
    endtask

    task automatic model_reset();
        m_in_rst  = 1'b1;
        m_pc      = R_PC;
        m_valid   = 1'b0;
        m_pend    = 1'b0;
        m_pend_pc = '0;
        m_mis     = 1'b0;
    endtask

    task automatic idle_inputs();
        br_req = 0; br_taken = 0; j_req = 0; jr_req = 0;
    endtask

    // One clock: model predicts from current inputs, outputs compared at negedge.
    task automatic step();
        bit          has_redir;
        logic [31:0] t;
        bit          xfer;
        has_redir = 1'b1;
        if (jr_req)                 t = jr_target;
        else if (j_req)             t = {m_pc[31:28], j_index, 2'b00};
        else if (br_req && br_taken) t = br_pc4 + (32'($signed(br_imm)) << 2);
        else begin
            has_redir = 1'b0;
            t = '0;
        end
        xfer = m_valid && fetch_ready;
        @(posedge clk);
        m_mis = 1'b0;
        if (m_in_rst) begin
            m_in_rst = 1'b0;
            m_valid  = !stall;
        end else begin
            if (has_redir && ALIGN && t[1:0] != 2'b00) begin
                t     = X_VEC;
                m_mis = 1'b1;
            end
            if (!m_valid || xfer) begin
                if (has_redir)   m_pc = t;
                else if (m_pend) m_pc = m_pend_pc;
                else if (xfer)   m_pc = m_pc + 32'd4;
                m_pend  = 1'b0;
                m_valid = !stall;
            end else if (has_redir) begin
                m_pend    = 1'b1;
                m_pend_pc = t;
            end
        end
        @(negedge clk);
        chk_model();
    endtask

    initial begin
        rst_n = 0; stall = 0; fetch_ready = 1;
        br_pc4 = '0; br_imm = '0; j_index = '0; jr_target = '0;
        idle_inputs();
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_pc", fetch_pc, R_PC);
        chk("rst_valid", 32'(fetch_valid), 32'd0);
        chk("rst_pending", 32'(redir_pending), 32'd0);
        chk("rst_mis", 32'(misalign), 32'd0);

        // Sequential fetch after reset release
        rst_n = 1;
        step(); chk("seq0", fetch_pc, 32'h3000); chk("seq0_valid", 32'(fetch_valid), 32'd1);
        step(); chk("seq1", fetch_pc, 32'h3004);
        step(); chk("seq2", fetch_pc, 32'h3008);

        // Taken branch with a transfer in the same cycle
        br_req = 1; br_taken = 1; br_pc4 = 32'h3010; br_imm = 16'hFFFC;
        step(); idle_inputs();
        chk("branch", fetch_pc, 32'h3000);

        // Untaken branch ignored
        br_req = 1; br_taken = 0; br_pc4 = 32'h9000;
        step(); idle_inputs();
        chk("br_not_taken", fetch_pc, 32'h3004);

        // Jump while fetch blocked at 0x3008
        step();
        fetch_ready = 0; j_req = 1; j_index = 26'h0000100;
        step(); idle_inputs();
        chk("j_hold_pc", fetch_pc, 32'h3008);
        chk("j_pending", 32'(redir_pending), 32'd1);
        fetch_ready = 1;
        step();
        chk("j_target", fetch_pc, 32'h0000_0400);
        chk("j_pend_clr", 32'(redir_pending), 32'd0);

        // jr beats a taken branch
        jr_req = 1; jr_target = 32'h5000; br_req = 1; br_taken = 1;
        step(); idle_inputs();
        chk("jr_prio", fetch_pc, 32'h5000);

        // Latest redirect wins in PEND
        fetch_ready = 0; jr_req = 1; jr_target = 32'h7000;
        step();
        jr_target = 32'h7100;
        step(); idle_inputs();
        chk("pend_hold", fetch_pc, 32'h5000);
        fetch_ready = 1;
        step();
        chk("pend_overwrite", fetch_pc, 32'h7100);

        // Overwrite and transfer in the same cycle
        fetch_ready = 0; jr_req = 1; jr_target = 32'h7200;
        step();
        fetch_ready = 1; jr_target = 32'h7300;
        step(); idle_inputs();
        chk("pend_same_cycle", fetch_pc, 32'h7300);

        // Stall from idle, redirect while stalled
        stall = 1;
        step();
        step(); chk("stall_valid", 32'(fetch_valid), 32'd0);
        step(); chk("stall_pc", fetch_pc, 32'h7304);
        jr_req = 1; jr_target = 32'h6000;
        step(); idle_inputs();
        chk("stall_jr", fetch_pc, 32'h6000);
        stall = 0;
        step(); chk("unstall_valid", 32'(fetch_valid), 32'd1);

        // Misaligned jr target
        jr_req = 1; jr_target = 32'h5002;
        step(); idle_inputs();
        chk("mis_pc", fetch_pc, ALIGN ? X_VEC : 32'h5002);
        chk("mis_pulse", 32'(misalign), ALIGN ? 32'd1 : 32'd0);
        step(); chk("mis_drop", 32'(misalign), 32'd0);

        // Reset while in PEND
        fetch_ready = 0; jr_req = 1; jr_target = 32'h8000;
        step(); idle_inputs();
        chk("pre_rst_pending", 32'(redir_pending), 32'd1);
        rst_n = 0;
        #1;
        model_reset();
        chk("pend_rst_pc", fetch_pc, 32'h3000);
        chk("pend_rst_pending", 32'(redir_pending), 32'd0);
        @(negedge clk);
        fetch_ready = 1;
        rst_n = 1;
        step();

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            stall       = ($urandom_range(0, 9) < 2);
            fetch_ready = ($urandom_range(0, 9) < 6);
            jr_req      = ($urandom_range(0, 9) == 0);
            j_req       = ($urandom_range(0, 9) == 0);
            br_req      = ($urandom_range(0, 9) < 2);
            br_taken    = $urandom_range(0, 1) == 1;
            br_pc4      = $urandom;
            br_imm      = 16'($urandom);
            j_index     = 26'($urandom);
            jr_target   = $urandom;
            if ($urandom_range(0, 3) != 0) jr_target[1:0] = 2'b00;
            if ($urandom_range(0, 3) != 0) br_pc4[1:0]    = 2'b00;
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_pc_sequencer
